// File: rtl/z16_mem_arbiter.sv
// Per-cycle arbiter sharing one single-port memory between Z16 fetch and load/store.
// Data has priority; a starvation counter forces fetch through after STARVE_LIMIT losses.
module z16_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MEM_AW       = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_valid,
  input  logic [15:0]       i_if_addr,
  output logic              o_if_ready,
  output logic              o_if_rvalid,
  output logic [15:0]       o_if_rdata,
  input  logic              i_d_valid,
  input  logic              i_d_we,
  input  logic [15:0]       i_d_addr,
  input  logic [15:0]       i_d_wdata,
  output logic              o_d_ready,
  output logic              o_d_rvalid,
  output logic [15:0]       o_d_rdata,
  output logic              o_d_misalign,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [MEM_AW-1:0] o_mem_addr,
  output logic [15:0]       o_mem_wdata,
  input  logic [15:0]       i_mem_rdata
);

  localparam int unsigned TAG_W = 2;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_IF   = 2'd1;
  localparam logic [1:0] TAG_D    = 2'd2;
  localparam logic [1:0] TAG_DZ   = 2'd3;

  logic [TAG_W-1:0] r_tag;
  logic [TAG_W-1:0] tag_nxt;
  logic [CNT_W-1:0] r_starve;
  logic [CNT_W-1:0] starve_nxt;
  logic             grant_if;
  logic             grant_d;
  logic             d_misaligned;
  logic             starve_hit;

  // Fetch address bit 0 is ignored; alignment is the core's responsibility.
  logic unused_ok;
  assign unused_ok = i_if_addr[0];

  assign starve_hit   = (r_starve >= CNT_W'(STARVE_LIMIT));
  assign d_misaligned = i_d_addr[0];

  // Tag and starvation state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tag    <= TAG_NONE;
      r_starve <= '0;
    end else begin
      r_tag    <= tag_nxt;
      r_starve <= starve_nxt;
    end
  end

  // Arbitration, memory issue and next-tag selection
  always_comb begin
    grant_if     = 1'b0;
    grant_d      = 1'b0;
    tag_nxt      = TAG_NONE;
    starve_nxt   = '0;
    o_if_ready   = 1'b0;
    o_d_ready    = 1'b0;
    o_d_misalign = 1'b0;
    o_mem_en     = 1'b0;
    o_mem_we     = 1'b0;
    o_mem_addr   = '0;
    o_mem_wdata  = '0;

    if (!i_rst) begin
      grant_d  = i_d_valid && (!i_if_valid || !starve_hit);
      grant_if = i_if_valid && !grant_d;

      o_if_ready   = grant_if;
      o_d_ready    = grant_d;
      o_d_misalign = grant_d && d_misaligned;

      if (grant_if) begin
        o_mem_en   = 1'b1;
        o_mem_addr = i_if_addr[MEM_AW:1];
        tag_nxt    = TAG_IF;
      end else if (grant_d && !d_misaligned) begin
        o_mem_en    = 1'b1;
        o_mem_we    = i_d_we;
        o_mem_addr  = i_d_addr[MEM_AW:1];
        o_mem_wdata = i_d_we ? i_d_wdata : 16'h0000;
        tag_nxt     = i_d_we ? TAG_NONE : TAG_D;
      end else if (grant_d && !i_d_we) begin
        // A dropped misaligned load still owes the requester a zero response.
        tag_nxt = TAG_DZ;
      end

      if (i_if_valid && !grant_if) begin
        starve_nxt = (r_starve == '1) ? r_starve : r_starve + CNT_W'(1);
      end
    end
  end

  // Response routing; reset suppresses any response still in flight.
  always_comb begin
    o_if_rvalid = !i_rst && (r_tag == TAG_IF);
    o_d_rvalid  = !i_rst && ((r_tag == TAG_D) || (r_tag == TAG_DZ));
    o_if_rdata  = o_if_rvalid ? i_mem_rdata : 16'h0000;
    o_d_rdata   = (o_d_rvalid && (r_tag == TAG_D)) ? i_mem_rdata : 16'h0000;
  end

endmodule

// File: tb/tb_z16_mem_arbiter.sv
// Directed bench for z16_mem_arbiter with a small behavioural memory behind it.
module tb_z16_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic [15:0] if_addr;
  logic        if_ready;
  logic        if_rvalid;
  logic [15:0] if_rdata;
  logic        d_valid;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ready;
  logic        d_rvalid;
  logic [15:0] d_rdata;
  logic        d_misalign;
  logic        mem_en;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic [15:0] mem [256];

  int vectors;
  int errors;

  z16_mem_arbiter #(.STARVE_LIMIT(4), .MEM_AW(15)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_valid(if_valid), .i_if_addr(if_addr), .o_if_ready(if_ready),
    .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
    .i_d_valid(d_valid), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_ready(d_ready), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
    .o_d_misalign(d_misalign),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port memory, one-cycle read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_in();
    if_valid = 1'b0; if_addr = 16'h0000;
    d_valid = 1'b0; d_we = 1'b0; d_addr = 16'h0000; d_wdata = 16'h0000;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] fa;
  logic [15:0] exp_if;
  int          prev;
  logic        is_if;

  initial begin
    vectors = 0;
    errors = 0;
    mem_rdata = 16'h0000;
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    idle_in();
    rst = 1'b1;
    tick();

    // Reset holds everything quiet even with requests pending
    if_valid = 1'b1; d_valid = 1'b1; d_addr = 16'h0011;
    #4;
    check("rst_if_ready", 32'(if_ready), 32'd0);
    check("rst_d_ready", 32'(d_ready), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_misalign", 32'(d_misalign), 32'd0);
    tick();
    #4;
    check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    check("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    check("rst_if_rdata", 32'(if_rdata), 32'd0);
    check("rst_d_rdata", 32'(d_rdata), 32'd0);
    tick();
    rst = 1'b0;
    idle_in();

    // Fetch only, back-to-back
    for (int k = 0; k < 3; k++) begin
      if_valid = 1'b1; if_addr = 16'(2 * k);
      #4;
      check("fo_if_ready", 32'(if_ready), 32'd1);
      check("fo_mem_en", 32'(mem_en), 32'd1);
      check("fo_mem_we", 32'(mem_we), 32'd0);
      check("fo_mem_addr", 32'(mem_addr), 32'(k));
      check("fo_if_rvalid", 32'(if_rvalid), (k > 0) ? 32'd1 : 32'd0);
      if (k > 0) check("fo_if_rdata", 32'(if_rdata), 32'h1000 + 32'(k - 1));
      tick();
    end
    idle_in();
    #4;
    check("fo_last_rvalid", 32'(if_rvalid), 32'd1);
    check("fo_last_rdata", 32'(if_rdata), 32'h1002);
    check("fo_idle_mem_en", 32'(mem_en), 32'd0);
    tick();
    #4;
    check("fo_done_rvalid", 32'(if_rvalid), 32'd0);
    tick();

    // Contention: D,D,D,D,IF repeating
    fa = 16'h0020; prev = 0; exp_if = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      if_valid = 1'b1; if_addr = fa;
      d_valid = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
      #4;
      is_if = ((i % 5) == 4);
      check("ct_d_ready", 32'(d_ready), is_if ? 32'd0 : 32'd1);
      check("ct_if_ready", 32'(if_ready), is_if ? 32'd1 : 32'd0);
      check("ct_mem_addr", 32'(mem_addr), is_if ? 32'(fa >> 1) : 32'h20);
      check("ct_d_rvalid", 32'(d_rvalid), (prev == 1) ? 32'd1 : 32'd0);
      check("ct_if_rvalid", 32'(if_rvalid), (prev == 2) ? 32'd1 : 32'd0);
      if (prev == 1) check("ct_d_rdata", 32'(d_rdata), 32'h1020);
      if (prev == 2) check("ct_if_rdata", 32'(if_rdata), 32'(exp_if));
      if (is_if) begin
        exp_if = 16'h1000 + (fa >> 1);
        fa = fa + 16'd2;
        prev = 2;
      end else begin
        prev = 1;
      end
      tick();
    end
    idle_in();
    #4;
    check("ct_tail_if_rvalid", 32'(if_rvalid), 32'd1);
    check("ct_tail_if_rdata", 32'(if_rdata), 32'(exp_if));
    tick();

    // Store then load
    d_valid = 1'b1; d_we = 1'b1; d_addr = 16'h0010; d_wdata = 16'hBEEF;
    #4;
    check("st_d_ready", 32'(d_ready), 32'd1);
    check("st_mem_en", 32'(mem_en), 32'd1);
    check("st_mem_we", 32'(mem_we), 32'd1);
    check("st_mem_addr", 32'(mem_addr), 32'h8);
    check("st_mem_wdata", 32'(mem_wdata), 32'hBEEF);
    tick();
    d_we = 1'b0;
    #4;
    check("ld_d_ready", 32'(d_ready), 32'd1);
    check("ld_mem_we", 32'(mem_we), 32'd0);
    check("ld_mem_addr", 32'(mem_addr), 32'h8);
    check("st_no_resp", 32'(d_rvalid), 32'd0);
    tick();
    idle_in();
    #4;
    check("ld_d_rvalid", 32'(d_rvalid), 32'd1);
    check("ld_d_rdata", 32'(d_rdata), 32'hBEEF);
    tick();

    // Misaligned load with fetch pending
    if_valid = 1'b1; if_addr = 16'h0030;
    d_valid = 1'b1; d_we = 1'b0; d_addr = 16'h0011;
    #4;
    check("ma_d_ready", 32'(d_ready), 32'd1);
    check("ma_misalign", 32'(d_misalign), 32'd1);
    check("ma_mem_en", 32'(mem_en), 32'd0);
    check("ma_if_ready", 32'(if_ready), 32'd0);
    tick();
    d_valid = 1'b0;
    #4;
    check("ma_d_rvalid", 32'(d_rvalid), 32'd1);
    check("ma_d_rdata", 32'(d_rdata), 32'h0);
    check("ma_if_ready2", 32'(if_ready), 32'd1);
    check("ma_misalign2", 32'(d_misalign), 32'd0);
    tick();
    // Misaligned store is dropped silently
    if_valid = 1'b0;
    d_valid = 1'b1; d_we = 1'b1; d_addr = 16'h0013; d_wdata = 16'h1234;
    #4;
    check("ms_misalign", 32'(d_misalign), 32'd1);
    check("ms_mem_en", 32'(mem_en), 32'd0);
    check("ms_mem_we", 32'(mem_we), 32'd0);
    check("ms_if_rvalid", 32'(if_rvalid), 32'd1);
    check("ms_if_rdata", 32'(if_rdata), 32'h1018);
    tick();
    idle_in();
    #4;
    check("ms_no_resp", 32'(d_rvalid), 32'd0);
    tick();

    // Reset mid-flight: raise r_starve to 2 first, then reset
    for (int i = 0; i < 2; i++) begin
      if_valid = 1'b1; if_addr = 16'h0020;
      d_valid = 1'b1; d_we = 1'b0; d_addr = 16'h0010;
      #4;
      check("rm_d_ready", 32'(d_ready), 32'd1);
      tick();
    end
    rst = 1'b1;
    d_addr = 16'h0040;
    for (int i = 0; i < 2; i++) begin
      #4;
      check("rm_d_rvalid", 32'(d_rvalid), 32'd0);
      check("rm_d_ready_rst", 32'(d_ready), 32'd0);
      check("rm_if_ready_rst", 32'(if_ready), 32'd0);
      check("rm_mem_en_rst", 32'(mem_en), 32'd0);
      tick();
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #4;
      check("rr_d_ready", 32'(d_ready), (i < 4) ? 32'd1 : 32'd0);
      check("rr_if_ready", 32'(if_ready), (i == 4) ? 32'd1 : 32'd0);
      if (i == 0) check("rr_d_rvalid", 32'(d_rvalid), 32'd0);
      tick();
    end
    idle_in();
    #4;
    check("rr_if_rvalid", 32'(if_rvalid), 32'd1);
    tick();

    // Idle
    for (int i = 0; i < 20; i++) begin
      #4;
      check("id_mem_en", 32'(mem_en), 32'd0);
      check("id_if_rvalid", 32'(if_rvalid), 32'd0);
      check("id_d_rvalid", 32'(d_rvalid), 32'd0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/z16_mem_arbiter.md
# z16_mem_arbiter

Shares a single-port synchronous unified memory between the Z16 instruction-fetch path and the load/store data path. It arbitrates per cycle with data priority, bounded by an anti-starvation counter for fetch. It issues one memory operation per cycle and tags in-flight reads so each one-cycle-latency read response returns to the correct requester. It sits between the Z16 core (fetch stage, load/store unit) and the memory macro.

## Interface
- STARVE_LIMIT, 4: consecutive cycles a valid fetch may lose before it is forced to win; legal range 1..15.
- MEM_AW, 15: memory word-address width.

- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_if_valid  in  1  fetch request.
- i_if_addr  in  16  fetch byte address.
- o_if_ready  out  1  fetch request accepted this cycle.
- o_if_rvalid  out  1  fetch data valid.
- o_if_rdata  out  16  fetched instruction.
- i_d_valid  in  1  data request.
- i_d_we  in  1  1 = store, 0 = load.
- i_d_addr  in  16  data byte address.
- i_d_wdata  in  16  store data.
- o_d_ready  out  1  data request accepted.
- o_d_rvalid  out  1  load data valid.
- o_d_rdata  out  16  load data.
- o_d_misalign  out  1  one-cycle pulse: odd data address was dropped.
- o_mem_en  out  1  memory operation this cycle.
- o_mem_we  out  1  memory write.
- o_mem_addr  out  MEM_AW  word address.
- o_mem_wdata  out  16  write data.
- i_mem_rdata  in  16  read data, valid the cycle after a read.

## Operation
- Handshake: a request completes when valid and ready are both 1 in the same cycle. A requester holds valid and the payload stable until ready. Ready is combinational from valid, the arbitration state and the address.
- Responses have no backpressure. Requesters must accept rvalid when it is asserted.
- Arbitration, per cycle:
  - Only one valid requester: that requester wins.
  - Both valid: data wins, unless r_starve >= STARVE_LIMIT, in which case fetch wins.
- r_starve (4-bit):
  - Increments, saturating at 15, when fetch is valid and loses.
  - Clears when fetch wins or fetch is not valid.
- Address mapping: o_mem_addr = addr[MEM_AW:1]. Bit 0 is ignored for fetch; fetch alignment is the core's job.
- Misaligned data request (i_d_addr[0] = 1) that wins arbitration:
  - o_d_ready = 1 and o_d_misalign = 1, pulsed in the same cycle.
  - No memory operation is issued; o_mem_en = 0 for that slot.
  - Fetch does not get the slot that cycle.
  - A misaligned load still returns o_d_rvalid = 1 next cycle with o_d_rdata = 0.
  - A misaligned store has no effect.
- Stores: o_mem_en = o_mem_we = 1 and o_mem_wdata = i_d_wdata. No response is returned.
- Response tag register r_tag ∈ {NONE, IF, D, DZ}, captured each cycle from the issued operation. Next cycle:
  - IF: o_if_rvalid = 1, o_if_rdata = i_mem_rdata.
  - D: o_d_rvalid = 1, o_d_rdata = i_mem_rdata.
  - DZ: o_d_rvalid = 1, o_d_rdata = 0.
  - NONE: no response.
- When an rvalid is 0, the corresponding rdata output is 0.
- No o_mem_* output depends on i_mem_rdata, so there is no combinational loop through memory.

## Timing
- Throughput: one accepted request per cycle, pipelined. Back-to-back reads from either port are allowed.
- Read latency: accept at cycle N, rvalid at N+1.
- Reset, applied synchronously on a rising edge:
  - r_tag = NONE, r_starve = 0.
  - o_if_rvalid = o_d_rvalid = 0, o_if_rdata = o_d_rdata = 0.
- While i_rst = 1: o_if_ready = o_d_ready = o_mem_en = o_mem_we = 0 and o_d_misalign = 0.
- Reset during a read in flight: the response is discarded; no rvalid appears after reset.
- Simultaneous accept (cycle N) and response (from cycle N-1) are independent and both occur.
- o_mem_we is 0 whenever o_mem_en is 0.
- Starvation bound: a continuously valid fetch is accepted within STARVE_LIMIT+1 cycles, including under continuous data requests.

## Test plan
- Fetch only: i_if_valid held at addr 0x0000, 0x0002, 0x0004 -> o_if_ready every cycle; o_mem_addr 0, 1, 2; o_if_rvalid one cycle later with memory contents in order.
- Contention: both ports valid continuously, STARVE_LIMIT = 4, data loads -> grant pattern D,D,D,D,IF repeating; every response is routed to the right port; fetch never waits more than 5 cycles.
- Store then load: D store 0xBEEF to 0x0010, then load 0x0010 -> o_mem_we = 1 with addr 8, then o_d_rvalid = 1 with rdata 0xBEEF one cycle after the load is accepted.
- Misaligned load to 0x0011 with fetch also valid -> o_d_ready = 1, o_d_misalign pulse, o_mem_en = 0, fetch not granted that cycle, o_d_rvalid = 1 with rdata 0x0000 next cycle.
- Reset mid-flight: load accepted at cycle N, i_rst = 1 at N+1 -> o_d_rvalid = 0 at N+1 and after; all readys = 0 while reset is high; r_starve = 0 afterwards, so contention restarts with 4 data wins before fetch.
- Idle: no valids -> o_mem_en = 0 and all rvalid outputs 0 for 20 cycles.
